sdram_init_rfsh_seq: RTL and testbench
======================================

SDRAM_INIT_RFSH_SEQ -- requirements
Module: sdram_init_rfsh_seq

Interface
REQ-001 Parameter INIT_WAIT, default 10000: NOP cycles after reset release before the first command.
REQ-002 Parameter INIT_REF, default 2: auto-refresh commands issued during initialization.
REQ-003 Parameter T_RP, default 2: precharge-to-next-command cycles.
REQ-004 Parameter T_RFC, default 7: refresh-to-next-command cycles.
REQ-005 Parameter T_MRD, default 2: load-mode-register to next-command cycles.
REQ-006 Parameter ADDR_W, default 13: SDRAM address width.
REQ-007 sdram_clk  in  1  sole clock; all state updates on its rising edge.
REQ-008 sdram_resetn  in  1  asynchronous, active-low reset.
REQ-009 cfg_mode_reg  in  ADDR_W  mode register value; sampled in the LMR cycle.
REQ-010 cfg_rfsh_period  in  16  cycles between periodic refreshes; 0 disables periodic refresh.
REQ-011 xfr_req  in  1  datapath requests the SDRAM command bus.
REQ-012 xfr_done  in  1  one-cycle pulse; datapath releases the bus with all banks precharged.
REQ-013 xfr_gnt  out  1  datapath owns the command bus.
REQ-014 init_done  out  1  initialization complete; stays high until reset.
REQ-015 cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n  out  1 each  SDRAM command, driven while xfr_gnt=0.
REQ-016 cmd_addr  out  ADDR_W  SDRAM address for the sequencer's own commands.
REQ-017 cfg_err  out  1  sticky; illegal cfg_mode_reg seen at LMR.
REQ-018 rfsh_miss  out  1  sticky; refresh period expired while a refresh was still pending.

Function
REQ-019 Command encoding (cs,ras,cas,we): NOP=0111, PRE=0010, REF=0001, LMR=0000; every non-command cycle SHALL be NOP once out of reset.
REQ-020 PRE SHALL drive cmd_addr[10]=1 (all banks) and cmd_addr[9:0]=0; NOP and REF SHALL drive cmd_addr=0.
REQ-021 States: WAIT, I_PRE, I_TRP, I_REF, I_TRFC, I_LMR, I_TMRD, IDLE, XFER, R_PRE, R_TRP, R_REF, R_TRFC.
REQ-022 WAIT: NOP for exactly INIT_WAIT cycles after reset deassertion, then I_PRE.
REQ-023 I_PRE issues one PRE, then T_RP-1 NOP cycles in I_TRP.
REQ-024 I_REF issues one REF, then T_RFC-1 NOP cycles in I_TRFC; this repeats until INIT_REF REFs have been issued, then I_LMR.
REQ-025 I_LMR issues LMR with cmd_addr = sanitized cfg_mode_reg; I_TMRD waits T_MRD-1 NOP cycles; init_done rises on entry to IDLE.
REQ-026 Sanitize: if bits[2:0]=111 (full page) and bit[3]=1, drive bit[3]=0 and set cfg_err.
REQ-027 Sanitize: if bits[6:4] is neither 010 nor 011, drive bits[6:4]=011 (CL3) and set cfg_err.
REQ-028 The refresh timer SHALL count only while init_done=1 and cfg_rfsh_period!=0; when it reaches cfg_rfsh_period-1 it SHALL reload to 0 and set rfsh_pend.
REQ-029 If the timer expires while rfsh_pend=1, rfsh_miss SHALL be set; the pending count stays at one.
REQ-030 IDLE priority: rfsh_pend -> R_PRE; else xfr_req -> XFER with xfr_gnt=1 from the next cycle.
REQ-031 XFER: xfr_gnt=1 and the command outputs hold NOP; xfr_done returns to IDLE with xfr_gnt=0 in the next cycle; a pending refresh does not preempt XFER.
REQ-032 R_PRE -> R_TRP (T_RP-1) -> R_REF -> R_TRFC (T_RFC-1) -> IDLE; rfsh_pend clears when REF issues.
REQ-033 xfr_req and xfr_done are ignored before init_done; xfr_done outside XFER is ignored.
REQ-034 A timer expiry in the same cycle as REF issue SHALL leave rfsh_pend=1 and SHALL NOT set rfsh_miss.

Reset
REQ-035 While sdram_resetn=0: state=WAIT, all counters 0, cmd_* = 1 (deselect), cmd_addr=0, xfr_gnt=0, init_done=0, cfg_err=0, rfsh_miss=0, rfsh_pend=0.
REQ-036 Reset asserted mid-sequence (including XFER) SHALL abort immediately and restart the full INIT_WAIT sequence after release.

Verification (INIT_WAIT=20, INIT_REF=2, T_RP=2, T_RFC=7, T_MRD=2)
REQ-037 Release reset, cfg_mode_reg=0x033 -> 20 NOP cycles, PRE with addr[10]=1, NOP, REF, 6 NOP, REF, 6 NOP, LMR with addr=0x033, NOP, init_done=1, cfg_err=0.
REQ-038 cfg_mode_reg=0x04F -> LMR addr=0x037, cfg_err=1.
REQ-039 cfg_rfsh_period=100, idle bus -> PRE, NOP, REF every 100 cycles; rfsh_miss=0.
REQ-040 xfr_req held, refresh expires during XFER, xfr_done 150 cycles later with period=100 -> refresh issued after xfr_done, rfsh_miss=1.
REQ-041 xfr_req and rfsh_pend both present in IDLE -> refresh first, then xfr_gnt=1 one cycle after entering IDLE.
REQ-042 Reset asserted during I_TRFC -> cmd_cs_n=1 immediately; after release the sequence restarts with 20 NOPs.

Source files
------------

// File: rtl/sdram_init_rfsh_seq.sv
// SDRAM power-up initialisation and periodic auto-refresh sequencer.
// It owns the command bus until init completes and then hands the bus to the datapath between refreshes.
module sdram_init_rfsh_seq #(
  parameter int INIT_WAIT = 10000,
  parameter int INIT_REF  = 2,
  parameter int T_RP      = 2,
  parameter int T_RFC     = 7,
  parameter int T_MRD     = 2,
  parameter int ADDR_W    = 13
) (
  input  logic              sdram_clk,
  input  logic              sdram_resetn,
  input  logic [ADDR_W-1:0] cfg_mode_reg,
  input  logic [15:0]       cfg_rfsh_period,
  input  logic              xfr_req,
  input  logic              xfr_done,
  output logic              xfr_gnt,
  output logic              init_done,
  output logic              cmd_cs_n,
  output logic              cmd_ras_n,
  output logic              cmd_cas_n,
  output logic              cmd_we_n,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic              cfg_err,
  output logic              rfsh_miss
);

  typedef enum logic [3:0] {
    WAIT, I_PRE, I_TRP, I_REF, I_TRFC, I_LMR, I_TMRD,
    IDLE, XFER, R_PRE, R_TRP, R_REF, R_TRFC
  } state_e;

  // {cs_n, ras_n, cas_n, we_n}
  typedef enum logic [3:0] {
    CMD_LMR   = 4'b0000,
    CMD_REF   = 4'b0001,
    CMD_PRE   = 4'b0010,
    CMD_NOP   = 4'b0111,
    CMD_DESEL = 4'b1111
  } cmd_e;

  localparam int MAX_D = (INIT_WAIT > T_RFC) ? INIT_WAIT : (T_RFC > T_RP ? (T_RFC > T_MRD ? T_RFC : T_MRD)
                                                                        : (T_RP > T_MRD ? T_RP : T_MRD));
  localparam int CNT_W = $clog2(MAX_D + 1);
  localparam int REF_W = $clog2(INIT_REF + 1);

  // Each wait state lasts T_x-1 cycles, so it leaves when the counter reaches T_x-2.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(INIT_WAIT);
  localparam logic [CNT_W-1:0] TRP_LAST  = CNT_W'((T_RP  > 1) ? T_RP  - 2 : 0);
  localparam logic [CNT_W-1:0] TRFC_LAST = CNT_W'((T_RFC > 1) ? T_RFC - 2 : 0);
  localparam logic [CNT_W-1:0] TMRD_LAST = CNT_W'((T_MRD > 1) ? T_MRD - 2 : 0);
  localparam logic [REF_W-1:0] REF_LAST  = REF_W'(INIT_REF);
  localparam logic [ADDR_W-1:0] PRE_ADDR = ADDR_W'(1) << 10;

  state_e            state, state_nxt;
  cmd_e              cmd_q, cmd_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [CNT_W-1:0]  dly_cnt, dly_nxt;
  logic [REF_W-1:0]  ref_cnt, ref_nxt;
  logic [15:0]       rfsh_tmr;
  logic              rfsh_pend;
  logic              rfsh_run;
  logic              rfsh_expire;
  logic              ref_issue;
  logic [ADDR_W-1:0] mode_fix;
  logic              mode_bad;

  assign {cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n} = cmd_q;

  assign rfsh_run    = init_done && (cfg_rfsh_period != 16'd0);
  assign rfsh_expire = rfsh_run && (rfsh_tmr >= cfg_rfsh_period - 16'd1);
  assign ref_issue   = (state == R_REF);

  // Full-page burst cannot be interleaved, and only CL2/CL3 are supported.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    mode_fix = cfg_mode_reg;
    mode_bad = 1'b0;
    if (cfg_mode_reg[2:0] == 3'b111 && cfg_mode_reg[3]) begin
      mode_fix[3] = 1'b0;
      mode_bad    = 1'b1;
    end
    if (cfg_mode_reg[6:4] != 3'b010 && cfg_mode_reg[6:4] != 3'b011) begin
      mode_fix[6:4] = 3'b011;
      mode_bad      = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    dly_nxt   = '0;
    ref_nxt   = ref_cnt;
    case (state)
      WAIT:
        if (dly_cnt == WAIT_LAST) state_nxt = I_PRE;
        else                      dly_nxt   = dly_cnt + CNT_W'(1);
      I_PRE:
        state_nxt = (T_RP > 1) ? I_TRP : I_REF;
      I_TRP:
        if (dly_cnt == TRP_LAST) state_nxt = I_REF;
        else                     dly_nxt   = dly_cnt + CNT_W'(1);
      I_REF: begin
        ref_nxt = ref_cnt + REF_W'(1);
        if (T_RFC > 1)                  state_nxt = I_TRFC;
        else if (ref_nxt == REF_LAST)   state_nxt = I_LMR;
        else                            state_nxt = I_REF;
      end
      I_TRFC:
        if (dly_cnt == TRFC_LAST) state_nxt = (ref_cnt == REF_LAST) ? I_LMR : I_REF;
        else                      dly_nxt   = dly_cnt + CNT_W'(1);
      I_LMR:
        state_nxt = (T_MRD > 1) ? I_TMRD : IDLE;
      I_TMRD:
        if (dly_cnt == TMRD_LAST) state_nxt = IDLE;
        else                      dly_nxt   = dly_cnt + CNT_W'(1);
      IDLE:
        if (rfsh_pend)    state_nxt = R_PRE;
        else if (xfr_req) state_nxt = XFER;
      XFER:
        if (xfr_done) state_nxt = IDLE;
      R_PRE:
        state_nxt = (T_RP > 1) ? R_TRP : R_REF;
      R_TRP:
        if (dly_cnt == TRP_LAST) state_nxt = R_REF;
        else                     dly_nxt   = dly_cnt + CNT_W'(1);
      R_REF:
        state_nxt = (T_RFC > 1) ? R_TRFC : IDLE;
      R_TRFC:
        if (dly_cnt == TRFC_LAST) state_nxt = IDLE;
        else                      dly_nxt   = dly_cnt + CNT_W'(1);
      default:
        state_nxt = WAIT;
    endcase
  end

  // Commands are registered together with the state, so the bus shows the command of the current state.
  always_comb begin
    cmd_nxt  = CMD_NOP;
    addr_nxt = '0;
    case (state_nxt)
      I_PRE, R_PRE: begin
        cmd_nxt  = CMD_PRE;
        addr_nxt = PRE_ADDR;
      end
      I_REF, R_REF: cmd_nxt = CMD_REF;
      I_LMR: begin
        cmd_nxt  = CMD_LMR;
        addr_nxt = mode_fix;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state     <= WAIT;
      dly_cnt   <= '0;
      ref_cnt   <= '0;
      cmd_q     <= CMD_DESEL;
      cmd_addr  <= '0;
      xfr_gnt   <= 1'b0;
      init_done <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state     <= state_nxt;
      dly_cnt   <= dly_nxt;
      ref_cnt   <= ref_nxt;
      cmd_q     <= cmd_nxt;
      cmd_addr  <= addr_nxt;
      xfr_gnt   <= (state_nxt == XFER);
      init_done <= init_done | (state_nxt == IDLE);
      if (state_nxt == I_LMR && mode_bad) cfg_err <= 1'b1;
    end
  end

  // An expiry coinciding with REF issue re-arms the request instead of counting as a miss.
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      rfsh_tmr  <= '0;
      rfsh_pend <= 1'b0;
      rfsh_miss <= 1'b0;
    end else begin
      if (rfsh_run) rfsh_tmr <= rfsh_expire ? 16'd0 : rfsh_tmr + 16'd1;
      if (rfsh_expire) begin
        rfsh_pend <= 1'b1;
        if (rfsh_pend && !ref_issue) rfsh_miss <= 1'b1;
      end else if (ref_issue) begin
        rfsh_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sdram_init_rfsh_seq.sv
// Scoreboard bench: stimulus pushes expected commands and grants; a monitor pops them as the DUT emits them.
module tb_sdram_init_rfsh_seq;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;

  typedef struct {
    bit          is_gnt;
    int          cyc;
    logic [3:0]  cmd;
    logic [12:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] cfg_mode_reg;
  logic [15:0] cfg_rfsh_period;
  logic        xfr_req;
  logic        xfr_done;
  logic        xfr_gnt;
  logic        init_done;
  logic        cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n;
  logic [12:0] cmd_addr;
  logic        cfg_err;
  logic        rfsh_miss;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc;
  logic [3:0]  mon_cmd;
  logic        prev_gnt;
  exp_t        mon_e;

  sdram_init_rfsh_seq #(
    .INIT_WAIT(20), .INIT_REF(2), .T_RP(2), .T_RFC(7), .T_MRD(2), .ADDR_W(13)
  ) dut (
    .sdram_clk       (clk),
    .sdram_resetn    (rst_n),
    .cfg_mode_reg    (cfg_mode_reg),
    .cfg_rfsh_period (cfg_rfsh_period),
    .xfr_req         (xfr_req),
    .xfr_done        (xfr_done),
    .xfr_gnt         (xfr_gnt),
    .init_done       (init_done),
    .cmd_cs_n        (cmd_cs_n),
    .cmd_ras_n       (cmd_ras_n),
    .cmd_cas_n       (cmd_cas_n),
    .cmd_we_n        (cmd_we_n),
    .cmd_addr        (cmd_addr),
    .cfg_err         (cfg_err),
    .rfsh_miss       (rfsh_miss)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; sample k at a negedge follows edge k.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_cmd(input int c, input logic [3:0] cmd, input logic [12:0] addr);
    exp_t e;
    e.is_gnt = 1'b0; e.cyc = c; e.cmd = cmd; e.addr = addr;
    exp_q.push_back(e);
  endtask

  task automatic push_gnt(input int c);
    exp_t e;
    e.is_gnt = 1'b1; e.cyc = c; e.cmd = C_NOP; e.addr = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_init(input logic [12:0] lmr_addr);
    push_cmd(21, C_PRE, 13'h400);
    push_cmd(23, C_REF, 13'h000);
    push_cmd(30, C_REF, 13'h000);
    push_cmd(37, C_LMR, lmr_addr);
  endtask

  task automatic push_rfsh(input int c);
    push_cmd(c,     C_PRE, 13'h400);
    push_cmd(c + 2, C_REF, 13'h000);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Asserts reset mid-cycle, checks the deselected outputs, and releases on a negedge.
  task automatic do_reset(input logic [12:0] mode, input logic [15:0] period);
    @(negedge clk);
    check("q_empty_before_reset", exp_q.size(), 0);
    exp_q.delete();
    #2;
    rst_n = 1'b0;
    xfr_req = 1'b0;
    xfr_done = 1'b0;
    cfg_mode_reg = mode;
    cfg_rfsh_period = period;
    #1;
    check("rst_cmd", {cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n}, 4'b1111);
    check("rst_addr", cmd_addr, 0);
    check("rst_flags", {xfr_gnt, init_done, cfg_err, rfsh_miss}, 4'b0000);
    repeat (3) @(negedge clk);
    check("rst_hold_cs", cmd_cs_n, 1'b1);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gnt = 1'b0;
    end else begin
      mon_cmd = {cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n};
      if (mon_cmd[3] == 1'b0 && mon_cmd != C_NOP) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_cmd: got cmd %b at cycle %0d, expected no command", mon_cmd, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("evt_is_cmd", 1'b0, mon_e.is_gnt);
          check("cmd_cycle", cyc, mon_e.cyc);
          check("cmd_code", mon_cmd, mon_e.cmd);
          check("cmd_addr", cmd_addr, mon_e.addr);
        end
      end else if (mon_cmd == C_NOP) begin
        check("nop_addr", cmd_addr, 0);
      end
      if (xfr_gnt && !prev_gnt) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_gnt: got xfr_gnt rise at cycle %0d, expected none", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("evt_is_gnt", 1'b1, mon_e.is_gnt);
          check("gnt_cycle", cyc, mon_e.cyc);
        end
      end
      prev_gnt = xfr_gnt;
    end
  end

  initial begin
    rst_n = 1'b0;
    xfr_req = 1'b0;
    xfr_done = 1'b0;
    cfg_mode_reg = 13'h033;
    cfg_rfsh_period = 16'd0;
    prev_gnt = 1'b0;

    // Start init, then abort with reset inside the first tRFC window.
    do_reset(13'h033, 16'd0);
    push_cmd(21, C_PRE, 13'h400);
    push_cmd(23, C_REF, 13'h000);
    wait_until(1);
    check("first_cmd_nop", {cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n}, C_NOP);
    wait_until(25);

    // Full init sequence after the aborted one.
    do_reset(13'h033, 16'd0);
    push_init(13'h033);
    wait_until(38);
    check("init_done_early", init_done, 1'b0);
    wait_until(39);
    check("init_done", init_done, 1'b1);
    check("cfg_err_clean", cfg_err, 1'b0);
    wait_until(45);

    // Full page with interleave plus bad CAS latency.
    do_reset(13'h04F, 16'd0);
    push_init(13'h037);
    wait_until(36);
    check("cfg_err_before_lmr", cfg_err, 1'b0);
    wait_until(37);
    check("cfg_err_04f", cfg_err, 1'b1);
    wait_until(45);

    // CAS latency 1 only.
    do_reset(13'h01B, 16'd0);
    push_init(13'h03B);
    wait_until(40);
    check("cfg_err_01b", cfg_err, 1'b1);

    // Legal CL2 full page; request and stray done during init are ignored.
    do_reset(13'h027, 16'd0);
    xfr_req = 1'b1;
    push_init(13'h027);
    push_gnt(40);
    wait_until(30);
    xfr_done = 1'b1;
    wait_until(31);
    xfr_done = 1'b0;
    check("gnt_during_init", xfr_gnt, 1'b0);
    wait_until(41);
    check("cfg_err_027", cfg_err, 1'b0);
    check("gnt_after_init", xfr_gnt, 1'b1);
    wait_until(44);
    xfr_done = 1'b1;
    xfr_req = 1'b0;
    wait_until(45);
    xfr_done = 1'b0;
    check("gnt_release", xfr_gnt, 1'b0);
    wait_until(50);

    // Periodic refresh on an idle bus, then a long transfer that misses one.
    do_reset(13'h033, 16'd100);
    push_init(13'h033);
    push_rfsh(140);
    push_rfsh(240);
    push_rfsh(340);
    wait_until(345);
    check("no_miss_idle", rfsh_miss, 1'b0);
    wait_until(350);
    xfr_req = 1'b1;
    push_gnt(351);
    wait_until(538);
    check("no_miss_yet", rfsh_miss, 1'b0);
    wait_until(539);
    check("miss_in_xfer", rfsh_miss, 1'b1);
    check("gnt_held", xfr_gnt, 1'b1);
    wait_until(589);
    xfr_done = 1'b1;
    wait_until(590);
    xfr_done = 1'b0;
    check("gnt_drop", xfr_gnt, 1'b0);
    push_rfsh(591);
    push_gnt(601);
    wait_until(609);
    xfr_done = 1'b1;
    xfr_req = 1'b0;
    wait_until(610);
    xfr_done = 1'b0;
    check("gnt_drop2", xfr_gnt, 1'b0);
    push_rfsh(640);
    wait_until(650);
    check("miss_sticky", rfsh_miss, 1'b1);

    // Expiry on the REF cycle re-arms the request without a miss.
    do_reset(13'h033, 16'd100);
    push_init(13'h033);
    push_rfsh(140);
    wait_until(139);
    cfg_rfsh_period = 16'd4;
    wait_until(143);
    cfg_rfsh_period = 16'd0;
    check("no_miss_on_ref", rfsh_miss, 1'b0);
    push_rfsh(150);
    wait_until(160);
    check("no_miss_after", rfsh_miss, 1'b0);

    @(negedge clk);
    check("q_empty_end", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
